branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with saturating-counter direction prediction (BHT).
- Sits beside the IF-stage PC. Predicts the next fetch address for branches and jumps in the same cycle.
- Is trained by the MEM-stage branch resolution.
- Also produces the mispredict/redirect signal that drives IF/ID and ID/EX flush, so flushes occur only on mispredict instead of on every taken branch.

Parameters:
- ENTRIES, 64, number of BTB/BHT entries; power of two, 4..1024.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
- TAG_W, 8, tag bits stored per entry; 1..(30-IDX_W).
- CNT_W, 2, saturating counter width; 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- lk_pc  in  32  IF-stage PC to look up.
- pred_hit  out  1  lk_pc hits a valid entry.
- pred_taken  out  1  predicted taken.
- pred_target  out  32  predicted next PC.
- upd_valid  in  1  MEM stage holds a resolved branch or jump this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_uncond  in  1  resolved instruction is JAL/JALR (always taken).
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual target when taken.
- upd_pred_taken  in  1  pred_taken carried down the pipeline with this instruction.
- upd_pred_target  in  32  pred_target carried down the pipeline.
- clear  in  1  synchronous invalidate of all entries (e.g. after self-modifying code).
- mispredict  out  1  resolution disagrees with prediction; flush IF/ID and ID/EX.
- redirect_pc  out  32  correct next PC when mispredict=1.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - pc[1:0] ignored.
- Entry contents: valid, tag[TAG_W], target[32], cnt[CNT_W], uncond.
- Lookup (combinational, zero latency):
  - pred_hit = valid[idx] & (tag[idx]==lk_tag).
  - pred_taken = pred_hit & (uncond[idx] | cnt[idx][CNT_W-1]).
  - pred_target = pred_taken ? target[idx] : lk_pc+4 (mod 2^32, wrap from 0xFFFFFFFC to 0).
- Resolution (combinational from upd_* inputs, gated by upd_valid):
  - mispredict = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & (upd_pred_target != upd_target))).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Update at posedge when upd_valid=1, on entry u = upd idx:
  - Hit (valid & tag match):
    - uncond=1: cnt := max; target := upd_target; uncond := 1.
    - Conditional, taken: cnt := sat-inc (holds at 2^CNT_W-1); target := upd_target.
    - Conditional, not taken: cnt := sat-dec (holds at 0); target unchanged.
  - Miss, taken: allocate (overwrite whatever occupies u).
    - valid := 1; tag := upd tag; target := upd_target; uncond := upd_uncond.
    - cnt := uncond ? max : 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
  - Aliasing: different PCs with the same idx and tag share an entry; accepted.
- Reset / clear:
  - reset=1 or clear=1 at posedge: all valid := 0, cnt := 0; target/tag need not be reset.
  - reset and clear have priority over a simultaneous update, which is discarded.
  - Outputs immediately after reset: pred_hit=0, pred_taken=0, pred_target=lk_pc+4. mispredict follows upd_* combinationally; 0 while upd_valid=0.
- Simultaneous lookup and update to the same idx: lookup returns pre-update contents; the new contents are visible from the next cycle. No bypass.
- Pipeline stall: the predictor holds no per-instruction state. The caller carries pred_taken and pred_target through the stage registers, and upd_valid must be 1 for exactly one cycle per resolved instruction.

Optional Feature:
- Macro BPU_STATS_EN.
- Defined: adds outputs stat_lookups[32], stat_branches[32], stat_mispredicts[32].
  - stat_lookups increments every cycle pred_hit=1.
  - stat_branches increments on upd_valid.
  - stat_mispredicts increments on mispredict.
  - All counters wrap at 2^32 and clear on reset (not on clear).
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then lk_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0x00000044; upd_valid=0 -> mispredict=0.
- Update upd_pc=0x40, conditional, taken, target=0x100, pred_taken=0 -> same cycle mispredict=1, redirect_pc=0x100. Next cycle lk_pc=0x40 -> pred_hit=1, pred_taken=1 (cnt=2), pred_target=0x100.
- Counter saturation on 0x40: taken twice -> cnt=3 (stays 3 on a further taken). Then not-taken x2 -> cnt=1, pred_taken=0, pred_target=0x44. Not-taken x2 more -> cnt=0 (holds), entry stays valid.
- JAL resolution upd_pc=0x80, uncond=1, target=0x200 -> lookup 0x80 gives pred_taken=1, target=0x200. Later resolved with pred_target=0x200 but upd_target=0x204 -> mispredict=1, redirect_pc=0x204.
- Same-idx conflict (ENTRIES=64): 0x40 allocated, then taken branch at 0x40+0x100 (same idx, different tag) -> 0x40 misses afterwards. Lookup of 0x40 in the same cycle as that update still sees the old entry.
- clear=1 together with upd_valid=1 -> next cycle every lookup misses and the update is discarded. With BPU_STATS_EN, stat_branches still counts it and stat_* are unchanged by clear, zeroed by reset.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// BPU_STATS_EN adds the free-running statistics counters to the bundle.
interface branch_predictor_if;
  logic [31:0] lk_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_uncond;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        clear;

  logic        mispredict;
  logic [31:0] redirect_pc;

`ifdef BPU_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  modport master (
    output lk_pc, upd_valid, upd_pc, upd_uncond, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, clear,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc
`ifdef BPU_STATS_EN
   ,input  stat_lookups, stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  lk_pc, upd_valid, upd_pc, upd_uncond, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, clear,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc
`ifdef BPU_STATS_EN
   ,output stat_lookups, stat_branches, stat_mispredicts
`endif
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating-counter direction prediction and mispredict detection.
// Optional BPU_STATS_EN adds lookup/branch/mispredict counters.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] uncond_q;
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, u_idx;
  logic [TAG_W-1:0] lk_tag, u_tag;
  logic             lk_hit, u_hit;

  // pc[1:0] and the bits above the tag never take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.lk_pc, bp.upd_pc};

  assign lk_idx = bp.lk_pc[IDX_W+1:2];
  assign lk_tag = bp.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx  = bp.upd_pc[IDX_W+1:2];
  assign u_tag  = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads the pre-update array; a same-cycle write shows up next cycle.
  assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign bp.pred_hit    = lk_hit;
  assign bp.pred_taken  = lk_hit && (uncond_q[lk_idx] || cnt_q[lk_idx][CNT_W-1]);
  assign bp.pred_target = bp.pred_taken ? target_q[lk_idx] : bp.lk_pc + 32'd4;

  assign bp.mispredict  = bp.upd_valid &&
                          ((bp.upd_pred_taken != bp.upd_taken) ||
                           (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));
  assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;

  logic             flush, hit_upd, alloc, wr_target, wr_uncond;
  logic [CNT_W-1:0] cnt_next;

  assign flush     = reset || bp.clear;
  assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign hit_upd   = bp.upd_valid && !flush && u_hit;
  assign alloc     = bp.upd_valid && !flush && !u_hit && bp.upd_taken;
  assign wr_target = alloc || (hit_upd && (bp.upd_uncond || bp.upd_taken));
  assign wr_uncond = alloc || (hit_upd && bp.upd_uncond);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_next = cnt_q[u_idx];
    if (alloc)
      cnt_next = bp.upd_uncond ? CNT_MAX : CNT_WEAK;
    else if (bp.upd_uncond)
      cnt_next = CNT_MAX;
    else if (bp.upd_taken) begin
      if (cnt_q[u_idx] != CNT_MAX) cnt_next = cnt_q[u_idx] + CNT_W'(1);
    end else begin
      if (cnt_q[u_idx] != '0) cnt_next = cnt_q[u_idx] - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (flush) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= '0;
    end else if (alloc || hit_upd) begin
      valid_q[u_idx] <= 1'b1;
      cnt_q[u_idx]   <= cnt_next;
    end
  end

  // NOTE: tag/target/uncond have no reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (wr_target) target_q[u_idx] <= bp.upd_target;
    if (alloc)     tag_q[u_idx]    <= u_tag;
    if (wr_uncond) uncond_q[u_idx] <= bp.upd_uncond;
  end

`ifdef BPU_STATS_EN
  logic [31:0] lookups_q, branches_q, mispredicts_q;

  // Statistics survive clear; only reset zeroes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      lookups_q     <= '0;
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      if (lk_hit)        lookups_q     <= lookups_q + 32'd1;
      if (bp.upd_valid)  branches_q    <= branches_q + 32'd1;
      if (bp.mispredict) mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign bp.stat_lookups     = lookups_q;
  assign bp.stat_branches    = branches_q;
  assign bp.stat_mispredicts = mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed vectors queue expectations per cycle,
// a negedge monitor pops and compares them. Stat checks apply when BPU_STATS_EN is defined.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_if bp ();
  branch_predictor dut (.clk(clk), .reset(reset), .bp(bp));

  typedef enum {K_LK, K_UP, K_ST} kind_e;
  typedef struct {
    string       name;
    int          cyc;
    kind_e       kind;
    logic [31:0] a, b, c;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(string n, kind_e k, logic [31:0] a, logic [31:0] b, logic [31:0] c);
    exp_t e;
    e.name = n; e.cyc = cyc; e.kind = k; e.a = a; e.b = b; e.c = c;
    q.push_back(e);
  endtask

  task automatic exp_lk(string n, logic h, logic t, logic [31:0] tg);
    push(n, K_LK, {30'b0, h, t}, tg, 32'b0);
  endtask

  task automatic exp_up(string n, logic m, logic [31:0] r);
    push(n, K_UP, {31'b0, m}, r, 32'b0);
  endtask

  task automatic upd(logic v, logic [31:0] pc, logic unc, logic tk, logic [31:0] tgt,
                     logic ptk, logic [31:0] ptgt);
    bp.upd_valid = v; bp.upd_pc = pc; bp.upd_uncond = unc; bp.upd_taken = tk;
    bp.upd_target = tgt; bp.upd_pred_taken = ptk; bp.upd_pred_target = ptgt;
  endtask

  task automatic idle();
    upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the predictor's outputs are combinational, so they are presented every cycle.
  exp_t        m_e;
  logic [31:0] m_a, m_b, m_c;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      checks++;
      m_a = 32'b0; m_b = 32'b0; m_c = 32'b0;
      case (m_e.kind)
        K_LK: begin m_a = {30'b0, bp.pred_hit, bp.pred_taken}; m_b = bp.pred_target; end
        K_UP: begin m_a = {31'b0, bp.mispredict}; m_b = bp.redirect_pc; end
        K_ST: begin
`ifdef BPU_STATS_EN
          m_a = bp.stat_lookups; m_b = bp.stat_branches; m_c = bp.stat_mispredicts;
`endif
        end
        default: ;
      endcase
      if (m_e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: not sampled in its cycle (queued %0d, now %0d)", m_e.name, m_e.cyc, cyc);
      end else if (m_a !== m_e.a || m_b !== m_e.b || m_c !== m_e.c) begin
        errors++;
        $display("FAIL %s: got %h/%h/%h expected %h/%h/%h",
                 m_e.name, m_a, m_b, m_c, m_e.a, m_e.b, m_e.c);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    bp.clear = 1'b0;
    bp.lk_pc = 32'h0;
    idle();
    tick(); tick();
    reset = 1'b0;

    // After reset: everything misses, no mispredict while idle.
    bp.lk_pc = 32'h40;
    exp_lk("reset_lookup", 1'b0, 1'b0, 32'h44);
    exp_up("reset_idle_misp", 1'b0, 32'h4);
    tick();

    // Allocate 0x40; same-cycle lookup still misses.
    upd(1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    exp_up("alloc_misp", 1'b1, 32'h100);
    exp_lk("alloc_same_cycle", 1'b0, 1'b0, 32'h44);
    tick();

    // Idle with a disagreeing upd bundle: gated by upd_valid.
    upd(1'b0, 32'h40, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100);
    exp_lk("weak_taken", 1'b1, 1'b1, 32'h100);
    exp_up("gated_misp", 1'b0, 32'h44);
    tick();

    // Three taken: 2 -> 3 -> 3 -> 3.
    for (int i = 0; i < 3; i++) begin
      upd(1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100);
      exp_up("taken_correct", 1'b0, 32'h100);
      exp_lk("taken_lookup", 1'b1, 1'b1, 32'h100);
      tick();
    end

    // Not taken twice: 3 -> 2 -> 1; predicted taken, so both mispredict.
    for (int i = 0; i < 2; i++) begin
      upd(1'b1, 32'h40, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100);
      exp_up("nt_misp", 1'b1, 32'h44);
      exp_lk("nt_lookup_before", 1'b1, 1'b1, 32'h100);
      tick();
    end

    idle();
    exp_lk("cnt1_not_taken", 1'b1, 1'b0, 32'h44);
    tick();

    // Two more not taken: 1 -> 0 -> 0 (holds), entry stays valid.
    for (int i = 0; i < 2; i++) begin
      upd(1'b1, 32'h40, 1'b0, 1'b0, 32'h100, 1'b0, 32'h44);
      exp_up("nt_correct", 1'b0, 32'h44);
      tick();
    end
    idle();
    exp_lk("cnt0_still_valid", 1'b1, 1'b0, 32'h44);
    tick();

    // JAL at 0x80.
    bp.lk_pc = 32'h0;
    upd(1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h84);
    exp_up("jal_alloc_misp", 1'b1, 32'h200);
    tick();
    idle();
    bp.lk_pc = 32'h80;
    exp_lk("jal_lookup", 1'b1, 1'b1, 32'h200);
    tick();
    upd(1'b1, 32'h80, 1'b1, 1'b1, 32'h204, 1'b1, 32'h200);
    exp_up("jal_target_misp", 1'b1, 32'h204);
    exp_lk("jal_old_target", 1'b1, 1'b1, 32'h200);
    tick();
    idle();
    exp_lk("jal_new_target", 1'b1, 1'b1, 32'h204);
    tick();

    // Same index, different tag: 0x140 evicts 0x40.
    bp.lk_pc = 32'h40;
    upd(1'b1, 32'h140, 1'b0, 1'b1, 32'h300, 1'b0, 32'h144);
    exp_up("conflict_misp", 1'b1, 32'h300);
    exp_lk("conflict_old_entry", 1'b1, 1'b0, 32'h44);
    tick();
    idle();
    exp_lk("conflict_evicted", 1'b0, 1'b0, 32'h44);
    tick();
    bp.lk_pc = 32'h140;
    exp_lk("conflict_new", 1'b1, 1'b1, 32'h300);
    tick();

    // Fall-through wraps at the top of the address space.
    bp.lk_pc = 32'hFFFF_FFFC;
    exp_lk("pc_wrap", 1'b0, 1'b0, 32'h0);
    tick();

    // Clear with a simultaneous update: update discarded.
    bp.lk_pc = 32'h80;
    bp.clear = 1'b1;
    upd(1'b1, 32'hC0, 1'b0, 1'b1, 32'h400, 1'b0, 32'hC4);
    exp_up("clear_misp", 1'b1, 32'h400);
    exp_lk("clear_same_cycle", 1'b1, 1'b1, 32'h204);
    tick();
    bp.clear = 1'b0;
    idle();
    exp_lk("clear_jal_gone", 1'b0, 1'b0, 32'h84);
    tick();
    bp.lk_pc = 32'hC0;
    exp_lk("clear_upd_dropped", 1'b0, 1'b0, 32'hC4);
    tick();
    bp.lk_pc = 32'h140;
    exp_lk("clear_cond_gone", 1'b0, 1'b0, 32'h144);
    tick();

    // Not-taken miss allocates nothing.
    bp.lk_pc = 32'h10;
    upd(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h14);
    exp_up("nt_miss_correct", 1'b0, 32'h14);
    tick();
    idle();
    exp_lk("nt_miss_no_alloc", 1'b0, 1'b0, 32'h14);
    tick();

`ifdef BPU_STATS_EN
    push("stats_totals", K_ST, 32'd16, 32'd13, 32'd7);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push("stats_reset", K_ST, 32'd0, 32'd0, 32'd0);
    tick();
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
